// File: rtl/uart_wb_sequencer.sv
// Wishbone master that programs uart_top after reset, then polls LSR to move bytes to/from RB/THR.
// Optional: define UART_SEQ_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module uart_wb_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 20000000,
  parameter int unsigned BAUDRATE    = 9600,
  parameter logic [7:0]  LCR_VALUE   = 8'h03,
  parameter int unsigned ACK_TIMEOUT = 5
) (
  input  logic       wb_clk_i,
  input  logic       wb_rstn_i,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  output logic [3:0] wbm_sel_o,
  input  logic       wbm_ack_i,
  input  logic       uart_int_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_ready_i,
  output logic       init_done_o,
  output logic       timeout_err_o
);

  localparam logic [15:0] Div16   = 16'(CLK_FREQ_HZ / (16 * BAUDRATE));
  localparam logic [7:0]  TmoLast = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {StInit, StIdle, StRdLsr, StRdRb, StWrThr} state_e;

  state_e     state_q, state_d;
  logic [2:0] init_idx_q, init_idx_d;
  logic       cyc_q, cyc_d, we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] tmo_q, tmo_d;
  logic       timeout_err_q, timeout_err_d;
  logic       init_done_q, init_done_d;
  logic       tx_ready_q, tx_ready_d;
  logic       rr_tx_q, rr_tx_d;  // 1: last side served was TX

  logic       done, push, rx_pop, rx_space, rx_cand, tx_cand;
  logic [7:0] rd_data;
  logic [2:0] init_adr;
  logic [7:0] init_dat;

  always_comb begin
    init_adr = 3'd1;
    init_dat = 8'h01;
    unique case (init_idx_q)
      3'd0:    begin init_adr = 3'd3; init_dat = 8'h80 | LCR_VALUE;  end
      3'd1:    begin init_adr = 3'd1; init_dat = Div16[15:8];        end
      3'd2:    begin init_adr = 3'd0; init_dat = Div16[7:0];         end
      3'd3:    begin init_adr = 3'd3; init_dat = LCR_VALUE & 8'h7F;  end
      3'd4:    begin init_adr = 3'd2; init_dat = 8'h06;              end
      default: begin init_adr = 3'd1; init_dat = 8'h01;              end
    endcase
  end

  assign done    = cyc_q & (wbm_ack_i | (tmo_q == TmoLast));
  assign rd_data = wbm_ack_i ? wbm_dat_i : 8'h00;
  assign rx_pop  = rx_valid_o & rx_ready_i;
  assign rx_cand = rd_data[0] & rx_space;
  assign tx_cand = rd_data[5] & tx_valid_i;

  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    cyc_d         = cyc_q;
    we_d          = we_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    init_done_d   = init_done_q;
    tx_ready_d    = 1'b0;
    rr_tx_d       = rr_tx_q;
    push          = 1'b0;

    if (cyc_q) begin
      tmo_d = tmo_q + 8'd1;
      if (done) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = 3'd0;
        dat_d = 8'h00;
        tmo_d = 8'd0;
        if (!wbm_ack_i) timeout_err_d = 1'b1;
      end
    end

    // Transactions are issued only while the bus is idle, which guarantees the idle gap.
    unique case (state_q)
      StInit: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = init_adr;
          dat_d = init_dat;
        end else if (done) begin
          if (init_idx_q == 3'd5) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
          end
        end
      end
      StIdle: begin
        if ((uart_int_i & rx_space) | tx_valid_i) state_d = StRdLsr;
      end
      StRdLsr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = 3'd5;
        end else if (done) begin
          if (rx_cand && (!tx_cand || rr_tx_q)) begin
            state_d = StRdRb;
            rr_tx_d = 1'b0;
          end else if (tx_cand) begin
            state_d = StWrThr;
            rr_tx_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRdRb: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = 3'd0;
        end else if (done) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      StWrThr: begin
        if (!cyc_q) begin
          if (tx_valid_i) begin
            cyc_d = 1'b1;
            we_d  = 1'b1;
            adr_d = 3'd0;
            dat_d = tx_data_i;
          end else begin
            state_d = StIdle;
          end
        end else if (done) begin
          tx_ready_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q       <= StInit;
      init_idx_q    <= 3'd0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= 3'd0;
      dat_q         <= 8'h00;
      tmo_q         <= 8'd0;
      timeout_err_q <= 1'b0;
      init_done_q   <= 1'b0;
      tx_ready_q    <= 1'b0;
      rr_tx_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      init_done_q   <= init_done_d;
      tx_ready_q    <= tx_ready_d;
      rr_tx_q       <= rr_tx_d;
    end
  end

`ifdef UART_SEQ_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(rx_pop);
    count_d  = count_q + 3'(push) - 3'(rx_pop);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= rd_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rx_space   = (count_q < 3'd4);
  assign rx_valid_o = (count_q != 3'd0);
  assign rx_data_o  = fifo_q[rd_ptr_q];
`else
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;

  always_comb begin
    rx_valid_d = push | (rx_valid_q & ~rx_pop);
    rx_data_d  = push ? rd_data : rx_data_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_space   = ~rx_valid_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
`endif

  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign wbm_sel_o     = cyc_q ? 4'b0001 : 4'b0000;
  assign tx_ready_o    = tx_ready_q;
  assign init_done_o   = init_done_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Directed bench for uart_wb_sequencer: behavioural Wishbone slave, transaction log, assertions.
module tb_uart_wb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] adr;
  logic [7:0] dat_o, dat_i;
  logic       we, stb, cyc, ack;
  logic [3:0] sel;
  logic       uart_int = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, init_done, timeout_err;
  logic [7:0] rx_data;

  logic       ack_en = 1'b1, noack_thr = 1'b0;
  logic [7:0] lsr_val = 8'h00, rb_val = 8'h00;

  int checks = 0;
  int failures = 0;
  int sel_bad = 0;
  int txr_cnt = 0;
  logic [11:0] log_q[$];  // {we, adr, data}
  logic [11:0] exp_init [6];

  always #5 clk = ~clk;

  uart_wb_sequencer dut (
    .wb_clk_i     (clk),
    .wb_rstn_i    (rst_n),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_we_o     (we),
    .wbm_stb_o    (stb),
    .wbm_cyc_o    (cyc),
    .wbm_sel_o    (sel),
    .wbm_ack_i    (ack),
    .uart_int_i   (uart_int),
    .tx_valid_i   (tx_valid),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready),
    .rx_valid_o   (rx_valid),
    .rx_data_o    (rx_data),
    .rx_ready_i   (rx_ready),
    .init_done_o  (init_done),
    .timeout_err_o(timeout_err)
  );

  assign ack   = ack_en & cyc & stb & ~(noack_thr & we);
  assign dat_i = (adr == 3'd5) ? lsr_val : (adr == 3'd0) ? rb_val : 8'h00;

  always @(posedge clk) begin
    if (cyc && stb && ack) log_q.push_back({we, adr, we ? dat_o : dat_i});
    if (cyc && sel != 4'b0001) sel_bad++;
    if (tx_ready) txr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
    check("init_done", 32'(init_done), 32'd1);
  endtask

  task automatic check_init(input string tag, input int base);
    logic [11:0] e;
    check($sformatf("%s_count", tag), 32'(log_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      e = (base + i < log_q.size()) ? log_q[base + i] : 12'hFFF;
      check($sformatf("%s_wr%0d", tag, i), 32'(e), 32'(exp_init[i]));
    end
  endtask

  task automatic wait_tx_ready(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (tx_ready) seen = 1;
    end
    tx_valid = 1'b0;
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int base, n, t0, rb_cnt, wr_cnt, k;
    logic [11:0] served [3];
    exp_init[0] = {1'b1, 3'd3, 8'h83};
    exp_init[1] = {1'b1, 3'd1, 8'h00};
    exp_init[2] = {1'b1, 3'd0, 8'h82};
    exp_init[3] = {1'b1, 3'd3, 8'h03};
    exp_init[4] = {1'b1, 3'd2, 8'h06};
    exp_init[5] = {1'b1, 3'd1, 8'h01};

    // Reset state
    cycles(3);
    check("rst_cyc_stb_we", {29'd0, cyc, stb, we}, 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_flags", {28'd0, init_done, timeout_err, rx_valid, tx_ready}, 32'd0);

    // 1: init sequence
    base = log_q.size();
    rst_n = 1'b1;
    wait_init();
    check_init("init", base);
    check("init_no_timeout", 32'(timeout_err), 32'd0);

    // 3: RX into storage, consumer stalled
    base = log_q.size();
    lsr_val = 8'h01; rb_val = 8'hA5; uart_int = 1'b1;
    cycles(80);
    rb_cnt = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i] == {1'b0, 3'd0, 8'hA5}) rb_cnt++;
`ifdef UART_SEQ_RX_FIFO_EN
    check("rx_rb_reads", 32'(rb_cnt), 32'd4);
    n = 4;
`else
    check("rx_rb_reads", 32'(rb_cnt), 32'd1);
    n = 1;
`endif
    check("rx_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'hA5);
    uart_int = 1'b0;
    cycles(10);
    rx_ready = 1'b1;
    cycles(n);
    rx_ready = 1'b0;
    check("rx_drained", 32'(rx_valid), 32'd0);

    // 4: TX single byte
    base = log_q.size(); t0 = txr_cnt;
    lsr_val = 8'h20; tx_data = 8'h3C; tx_valid = 1'b1;
    wait_tx_ready("tx_ready_seen");
    cycles(10);
    check("tx_ready_pulses", 32'(txr_cnt - t0), 32'd1);
    wr_cnt = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i][11]) wr_cnt++;
    check("tx_write_count", 32'(wr_cnt), 32'd1);
    check("tx_write", 32'(log_q[log_q.size() - 1]), 32'({1'b1, 3'd0, 8'h3C}));

    // 5: RX/TX alternation
    base = log_q.size();
    lsr_val = 8'h21; rb_val = 8'h5A; tx_data = 8'hC3;
    uart_int = 1'b1; rx_ready = 1'b1; tx_valid = 1'b1;
    wait_tx_ready("alt_tx_ready_seen");
    cycles(20);
    uart_int = 1'b0;
    cycles(20);
    rx_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) served[i] = 12'hFFF;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i][10:8] != 3'd5 && k < 3) begin
        served[k] = log_q[i];
        k++;
      end
    end
    check("alt_0_rb", 32'(served[0]), 32'({1'b0, 3'd0, 8'h5A}));
    check("alt_1_thr", 32'(served[1]), 32'({1'b1, 3'd0, 8'hC3}));
    check("alt_2_rb", 32'(served[2]), 32'({1'b0, 3'd0, 8'h5A}));

    // 2: LSR read never acked
    ack_en = 1'b0; tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && !stb; i++) @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 40 && stb; i++) begin
      n++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", 32'(n), 32'd5);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    cycles(10);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
    check("tmo_bus_idle", 32'(cyc), 32'd0);
    ack_en = 1'b1;

    // 6: reset during a stalled THR write
    noack_thr = 1'b1; lsr_val = 8'h20; tx_data = 8'h77; tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n == 0; i++) begin
      @(negedge clk);
      if (cyc && we) n = 1;
    end
    check("thr_write_started", 32'(n), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {29'd0, cyc, stb, we}, 32'd0);
    check("mid_rst_flags", {30'd0, init_done, timeout_err}, 32'd0);
    tx_valid = 1'b0; noack_thr = 1'b0;
    base = log_q.size();
    cycles(3);
    rst_n = 1'b1;
    wait_init();
    check_init("reinit", base);
    check("sel_during_cycles", 32'(sel_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
